// File: rtl/sx_exu_fpu_sched.sv
`default_nettype none
// ============================================================================
// sx_exu_fpu_sched: in-order FP op queue, single-issue FPU scheduler, result
// writeback with flush handling. Optional sticky flags: SX_FPU_FFLAGS_EN.
// Revision: 1.0
// ============================================================================
module sx_exu_fpu_sched #(
  parameter int DEPTH = 2,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [2:0]      dec_op,
  input  logic [31:0]     dec_rs1,
  input  logic [31:0]     dec_rs2,
  input  logic [TAGW-1:0] dec_tag,
  input  logic            flush,
  output logic [2:0]      fpu_op,
  output logic [31:0]     fpu_rs1,
  output logic [31:0]     fpu_rs2,
  output logic            fpu_cancel,
  output logic            fpu_wb_ready,
  input  logic            fpu_busy,
  input  logic            fpu_result_ready,
  input  logic [31:0]     fpu_rd,
  input  logic [4:0]      fpu_status,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [TAGW-1:0] wb_tag,
  output logic [4:0]      fflags,
  output logic            idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]      q_op  [DEPTH];
  logic [31:0]     q_rs1 [DEPTH];
  logic [31:0]     q_rs2 [DEPTH];
  logic [TAGW-1:0] q_tag [DEPTH];

  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]   head;
  logic [TAGW-1:0] inflight_tag;
  logic            empty, full, push, issue, capture, wb_done;

  assign head    = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = dec_valid && dec_ready;
  assign issue   = rst_l && (state == ISSUE) && !fpu_busy && !flush && !empty;
  assign capture = (state == WAIT) && fpu_result_ready && !flush;
  assign wb_done = (state == WB) && wb_ready && !flush;

  assign dec_ready    = rst_l && !full && !flush;
  assign fpu_op       = issue ? q_op[head]  : 3'b000;
  assign fpu_rs1      = issue ? q_rs1[head] : 32'd0;
  assign fpu_rs2      = issue ? q_rs2[head] : 32'd0;
  assign fpu_cancel   = rst_l && (state == WAIT) && flush;
  assign fpu_wb_ready = rst_l && (state == WAIT);
  assign idle         = (state == IDLE) && empty;

  // Storage carries no reset; validity is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr[AW-1:0]]  <= dec_op;
      q_rs1[wr_ptr[AW-1:0]] <= dec_rs1;
      q_rs2[wr_ptr[AW-1:0]] <= dec_rs2;
      q_tag[wr_ptr[AW-1:0]] <= dec_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  // A same-cycle push counts as "non-empty" so issue can follow in the next cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!empty || push) state_nxt = ISSUE;
        ISSUE:   if (issue) state_nxt = WAIT;
        WAIT:    if (fpu_result_ready) state_nxt = WB;
        WB:      if (wb_ready) state_nxt = (!empty || push) ? ISSUE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_tag       <= '0;
      inflight_tag <= '0;
    end else begin
      if (issue) inflight_tag <= q_tag[head];
      if (capture) begin
        wb_valid <= 1'b1;
        wb_data  <= fpu_rd;
        wb_tag   <= inflight_tag;
      end else if (flush || wb_done) begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef SX_FPU_FFLAGS_EN
  logic [4:0] fflags_q;

  always_ff @(posedge clk) begin
    if (!rst_l)       fflags_q <= 5'd0;
    else if (capture) fflags_q <= fflags_q | fpu_status;
  end

  assign fflags = fflags_q;
`else
  logic unused_status;

  assign unused_status = ^fpu_status;
  assign fflags        = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sx_exu_fpu_sched.sv
`default_nettype none
// Random-stimulus bench for sx_exu_fpu_sched with an FPU model and a
// transaction-level scoreboard of outstanding decode ops.
module tb_sx_exu_fpu_sched;
  localparam int DEPTH = 2;
  localparam int TAGW  = 5;

  logic            clk = 1'b0;
  logic            rst_l;
  logic            dec_valid, dec_ready;
  logic [2:0]      dec_op;
  logic [31:0]     dec_rs1, dec_rs2;
  logic [TAGW-1:0] dec_tag;
  logic            flush;
  logic [2:0]      fpu_op;
  logic [31:0]     fpu_rs1, fpu_rs2;
  logic            fpu_cancel, fpu_wb_ready, fpu_busy, fpu_result_ready;
  logic [31:0]     fpu_rd;
  logic [4:0]      fpu_status;
  logic            wb_valid, wb_ready;
  logic [31:0]     wb_data;
  logic [TAGW-1:0] wb_tag;
  logic [4:0]      fflags;
  logic            idle;

  sx_exu_fpu_sched #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_l(rst_l),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_tag(dec_tag),
    .flush(flush),
    .fpu_op(fpu_op), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
    .fpu_cancel(fpu_cancel), .fpu_wb_ready(fpu_wb_ready), .fpu_busy(fpu_busy),
    .fpu_result_ready(fpu_result_ready), .fpu_rd(fpu_rd), .fpu_status(fpu_status),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .fflags(fflags), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TAGW-1:0] tag;
  } ent_t;

  // Ops accepted from decode and not yet written back, oldest first.
  ent_t pend[$];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  bit          head_issued, wb_pend, fpu_inflight;
  int unsigned fpu_cnt;
  logic [2:0]  h_op;
  logic [31:0] h_a, h_b;
  logic [4:0]  exp_fflags;
  bit          chk_en, exp_dec_ready, exp_wait, exp_wb_valid, exp_idle, exp_can_issue;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fres(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b100:  return a + b;
      3'b010:  return a * b;
      default: return (a ^ {b[15:0], b[31:16]}) + 32'h1357;
    endcase
  endfunction

  function automatic logic [4:0] fstat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = 5'd0;
    if (a[7:0] == 8'hFF)                          s[4] = 1'b1;
    if (op == 3'b001 && b[7:0] == 8'h00)          s[3] = 1'b1;
    if (op == 3'b010 && a[31] && b[31] && a[30])  s[2] = 1'b1;
    if (op == 3'b010 && a[7:0] == 8'h01)          s[1] = 1'b1;
    if (op == 3'b100 && a[5:0] == b[5:0])         s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic [2:0] rop();
    case ($urandom_range(0, 2))
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic clear_model();
    pend.delete();
    head_issued  = 1'b0;
    wb_pend      = 1'b0;
    fpu_inflight = 1'b0;
    fpu_cnt      = 0;
  endtask

  task automatic do_reset();
    chk_en           = 1'b0;
    rst_l            = 1'b0;
    dec_valid        = 1'b0;
    flush            = 1'b0;
    fpu_busy         = 1'b0;
    fpu_result_ready = 1'b0;
    wb_ready         = 1'b0;
    clear_model();
    exp_fflags = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dec_ready", 32'(dec_ready), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_fpu_cancel", 32'(fpu_cancel), 32'd0);
    chk("rst_fpu_wb_ready", 32'(fpu_wb_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    rst_l = 1'b1;
  endtask

  // Driver: decode source, FPU model, writeback sink, and expected-queue updates.
  initial begin
    int unsigned busy_pct, wb_pct;
    bit fl;
    dec_op  = 3'b100;
    dec_rs1 = 32'd0;
    dec_rs2 = 32'd0;
    dec_tag = '0;
    fpu_rd  = 32'd0;
    fpu_status = 5'd0;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if (c == 3000) do_reset();
      @(negedge clk);
      case ((c / 400) % 3)
        0:       begin busy_pct = 10; wb_pct = 80; end
        1:       begin busy_pct = 70; wb_pct = 30; end
        default: begin busy_pct = 0;  wb_pct = 95; end
      endcase
      fl = ($urandom_range(0, 99) < 3);
      exp_wait      = fpu_inflight;
      exp_wb_valid  = wb_pend;
      exp_idle      = (pend.size() == 0);
      exp_can_issue = (pend.size() > 0) && !head_issued;
      exp_dec_ready = !fl && ((pend.size() - int'(head_issued)) < DEPTH);
      chk_en        = 1'b1;

      flush     = fl;
      fpu_busy  = ($urandom_range(0, 99) < busy_pct);
      wb_ready  = ($urandom_range(0, 99) < wb_pct);
      dec_valid = ($urandom_range(0, 99) < 50);
      dec_op    = rop();
      dec_rs1   = ($urandom_range(0, 9) == 0) ? {$urandom_range(0, 65535), 8'hFF} : $urandom;
      dec_rs2   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      dec_tag   = TAGW'($urandom);
      if (fpu_inflight && fpu_cnt == 0) begin
        fpu_result_ready = 1'b1;
        fpu_rd           = fres(h_op, h_a, h_b);
        fpu_status       = fstat(h_op, h_a, h_b);
      end else begin
        fpu_result_ready = 1'b0;
        fpu_rd           = $urandom;
        fpu_status       = 5'($urandom);
      end
      #1;
      if (dec_valid && dec_ready) pend.push_back('{dec_op, dec_rs1, dec_rs2, dec_tag});
      if (fpu_result_ready && !flush && pend.size() > 0)
        exp_fflags = exp_fflags | fstat(pend[0].op, pend[0].a, pend[0].b);
      if (flush) begin
        pend.delete();
        head_issued = 1'b0;
        wb_pend     = 1'b0;
      end else if (fpu_result_ready) begin
        wb_pend = 1'b1;
      end else if (wb_pend && wb_ready) begin
        wb_pend = 1'b0;
      end
      if (flush || fpu_result_ready) fpu_inflight = 1'b0;
      else if (fpu_inflight && fpu_cnt > 0) fpu_cnt--;
      if (fpu_op != 3'b000) begin
        fpu_inflight = 1'b1;
        fpu_cnt      = $urandom_range(0, 3);
        h_op         = fpu_op;
        h_a          = fpu_rs1;
        h_b          = fpu_rs2;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  initial begin
    ent_t       e;
    logic [4:0] exp_ff;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && rst_l) begin
        chk("dec_ready", 32'(dec_ready), 32'(exp_dec_ready));
        chk("fpu_wb_ready", 32'(fpu_wb_ready), 32'(exp_wait));
        chk("fpu_cancel", 32'(fpu_cancel), 32'(flush && exp_wait));
        chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
        chk("idle", 32'(idle), 32'(exp_idle));
        if (exp_can_issue && !fpu_busy && !flush) begin
          chk("issue_op", 32'(fpu_op), 32'(pend[0].op));
          chk("issue_rs1", fpu_rs1, pend[0].a);
          chk("issue_rs2", fpu_rs2, pend[0].b);
          head_issued = 1'b1;
        end else begin
          chk("fpu_op_quiet", 32'(fpu_op), 32'd0);
        end
        if (exp_wb_valid && wb_valid && pend.size() > 0) begin
          e = pend[0];
          chk("wb_data", wb_data, fres(e.op, e.a, e.b));
          chk("wb_tag", 32'(wb_tag), 32'(e.tag));
          exp_ff = exp_fflags;
`ifndef SX_FPU_FFLAGS_EN
          exp_ff = 5'd0;
`endif
          chk("fflags", 32'(fflags), 32'(exp_ff));
          if (wb_ready && !flush) begin
            void'(pend.pop_front());
            head_issued = 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
